// File: rtl/yarp_imem_responder.sv
// yarp_imem_responder: instruction-memory responder for the YARP fetch path.
//
// A word-addressed backing store answers one read request per cycle with a
// fixed LATENCY-cycle pipeline and no backpressure. Misaligned or
// out-of-window reads return NOP_INSTR flagged with mem_rd_err_o. The store is
// filled through a separate preload port that shares no handshake with reads.
//
// Ports:
//   clk             - single clock, rising edge
//   reset_n         - asynchronous active-low reset (store contents survive it)
//   mem_req_i       - read request, sampled every rising edge
//   mem_addr_i      - byte address of the read
//   mem_rd_data_o   - response data; holds the last response when not valid
//   mem_rd_valid_o  - one-cycle pulse per response
//   mem_rd_err_o    - response was misaligned or out of range
//   load_en_i       - preload write strobe
//   load_addr_i     - preload byte address
//   load_data_i     - preload data
module yarp_imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_req_i,
  input  logic [31:0] mem_addr_i,
  output logic [31:0] mem_rd_data_o,
  output logic        mem_rd_valid_o,
  output logic        mem_rd_err_o,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SizeBytes = 32'(DEPTH_WORDS * 4);

  // Window check: unsigned subtraction makes addresses below BASE_ADDR wrap
  // to a huge offset, so a single compare covers both ends of the window.
  logic [31:0]     rd_off;
  logic [31:0]     ld_off;
  logic            rd_ok;
  logic            ld_ok;
  logic [IdxW-1:0] rd_idx;
  logic [IdxW-1:0] ld_idx;
  logic [31:0]     rd_word;

  assign rd_off = mem_addr_i - BASE_ADDR;
  assign ld_off = load_addr_i - BASE_ADDR;
  assign rd_ok  = (rd_off < SizeBytes) && (mem_addr_i[1:0] == 2'b00);
  assign ld_ok  = (ld_off < SizeBytes) && (load_addr_i[1:0] == 2'b00);
  assign rd_idx = rd_off[IdxW+1:2];
  assign ld_idx = ld_off[IdxW+1:2];

  // Backing store: deliberately not reset so preloaded code survives reset.
  logic [31:0] mem_q [DEPTH_WORDS];

  assign rd_word = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (load_en_i && ld_ok) begin
      mem_q[ld_idx] <= load_data_i;
    end
  end

  // Response pipeline. Stage 0 captures the store word at the sampling edge,
  // which gives read-before-write against a same-edge preload. Data/err only
  // advance behind a valid stage, so the last stage keeps the most recent
  // response data across bubbles.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [LATENCY-1:0] err_q;
  logic [LATENCY-1:0] err_d;
  logic [31:0]        dat_q [LATENCY];
  logic [31:0]        dat_d [LATENCY];

  always_comb begin
    vld_d = vld_q;
    err_d = err_q;
    dat_d = dat_q;
    vld_d[0] = mem_req_i;
    if (mem_req_i) begin
      dat_d[0] = rd_ok ? rd_word : NOP_INSTR;
      err_d[0] = ~rd_ok;
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dat_q[i] <= 32'h0;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  assign mem_rd_valid_o = vld_q[LATENCY-1];
  assign mem_rd_data_o  = dat_q[LATENCY-1];
  // err is only meaningful alongside valid; bubbles report 0.
  assign mem_rd_err_o   = vld_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: tb/tb_yarp_imem_responder.sv
// Bench for yarp_imem_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus stream. A reference model keeps a word array plus a per-edge
// history of request outcomes; the expected output of each instance is the
// history entry LATENCY-1 edges back, or the held data on a bubble.
module tb_yarp_imem_responder;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h0000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;
  localparam int          HistN = 4096;

  logic        clk;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        v1, v2, v3, e1, e2, e3;
  logic [31:0] d1, d2, d3;

  yarp_imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .LATENCY(1), .NOP_INSTR(Nop)) u_l1 (
    .clk(clk), .reset_n(reset_n), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
    .mem_rd_data_o(d1), .mem_rd_valid_o(v1), .mem_rd_err_o(e1),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );
  yarp_imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .LATENCY(2), .NOP_INSTR(Nop)) u_l2 (
    .clk(clk), .reset_n(reset_n), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
    .mem_rd_data_o(d2), .mem_rd_valid_o(v2), .mem_rd_err_o(e2),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );
  yarp_imem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .LATENCY(3), .NOP_INSTR(Nop)) u_l3 (
    .clk(clk), .reset_n(reset_n), .mem_req_i(mem_req), .mem_addr_i(mem_addr),
    .mem_rd_data_o(d3), .mem_rd_valid_o(v3), .mem_rd_err_o(e3),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  logic        dv [1:3];
  logic [31:0] dd [1:3];
  logic        de [1:3];

  always_comb begin
    dv[1] = v1; dv[2] = v2; dv[3] = v3;
    dd[1] = d1; dd[2] = d2; dd[3] = d3;
    de[1] = e1; de[2] = e2; de[3] = e3;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] ref_mem [0:Depth-1];
  logic        h_v [0:HistN-1];
  logic [31:0] h_d [0:HistN-1];
  logic        h_e [0:HistN-1];
  int          edge_n;
  logic [31:0] held [1:3];
  logic        ev [1:3];
  logic [31:0] ed [1:3];
  logic        ee [1:3];

  int n_cmp;
  int n_bad;

  logic [31:0] prog [0:3] = '{32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000073};

  function automatic logic in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (off < 32'(Depth * 4)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - Base) >> 2;
    return int'(off);
  endfunction

  // One clock edge: drive inputs, let the edge happen, advance the model,
  // then settle to 1 time unit after the edge for sampling.
  task automatic step(input logic req, input logic [31:0] addr, input logic ld,
                      input logic [31:0] la, input logic [31:0] ldat);
    int k;
    mem_req   = req;
    mem_addr  = addr;
    load_en   = ld;
    load_addr = la;
    load_data = ldat;
    @(posedge clk);
    if (edge_n < HistN) begin
      h_v[edge_n] = req && reset_n;
      h_e[edge_n] = !in_win(addr);
      h_d[edge_n] = in_win(addr) ? ref_mem[word_of(addr)] : Nop;
    end
    if (ld && in_win(la)) ref_mem[word_of(la)] = ldat;
    edge_n++;
    for (int l = 1; l <= 3; l++) begin
      k = edge_n - l;
      if (k >= 0 && k < HistN && h_v[k]) begin
        ev[l] = 1'b1; ed[l] = h_d[k]; ee[l] = h_e[k]; held[l] = h_d[k];
      end else begin
        ev[l] = 1'b0; ed[l] = held[l]; ee[l] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    for (int l = 1; l <= 3; l++) begin
      n_cmp++;
      if (dv[l] !== 1'b0 || dd[l] !== 32'h0 || de[l] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_init L%0d: got v=%b d=%h e=%b, want v=0 d=00000000 e=0",
                 l, dv[l], dd[l], de[l]);
      end
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== 1'b0 || dd[l] !== 32'h0 || de[l] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_hold L%0d: got v=%b d=%h e=%b, want v=0 d=00000000 e=0",
                   l, dv[l], dd[l], de[l]);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_preload();
    logic [31:0] w;
    for (int i = 0; i < int'(Depth); i++) begin
      if (i < 4) w = prog[i];
      else if (i == 4) w = 32'h11111111;
      else w = $urandom;
      step(1'b0, 32'h0, 1'b1, 32'(i * 4), w);
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL preload L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
    // Dropped loads: misaligned, one past the end, below-base wrap
    step(1'b0, 32'h0, 1'b1, 32'h0000_0006, 32'hBAD0_0001);
    step(1'b0, 32'h0, 1'b1, 32'(Depth * 4), 32'hBAD0_0002);
    step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hBAD0_0003);
  endtask

  task automatic test_program();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (i < 4) begin
        n_cmp++;
        if (dv[1] !== 1'b1 || dd[1] !== prog[i] || de[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL program_word%0d: got v=%b d=%h e=%b, want v=1 d=%h e=0",
                   i, dv[1], dd[1], de[1], prog[i]);
        end
      end
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL program L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [0:5];
    addrs = '{32'h0000_0002, 32'(Depth * 4), 32'hFFFF_FFFC, 32'h0000_0001, 32'h0, 32'h4};
    for (int i = 0; i < 9; i++) begin
      if (i < 6) step(1'b1, addrs[i], 1'b0, 32'h0, 32'h0);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (i < 2) begin
        n_cmp++;
        if (dv[1] !== 1'b1 || dd[1] !== 32'h00000013 || de[1] !== 1'b1) begin
          n_bad++;
          $display("FAIL error_read%0d: got v=%b d=%h e=%b, want v=1 d=00000013 e=1",
                   i, dv[1], dd[1], de[1]);
        end
      end
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL errors L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    logic       rq [0:5];
    logic [2:0] exp_v3 [0:5];
    rq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(rq[i], (i == 2) ? 32'h4 : 32'h0, 1'b0, 32'h0, 32'h0);
      // LATENCY=3 sees request i after edge i+2
      if (i >= 2 && i <= 4) begin
        n_cmp++;
        if (dv[3] !== rq[i-2] || dd[3] !== ((i == 4) ? prog[1] : prog[0])) begin
          n_bad++;
          $display("FAIL bubble_l3_%0d: got v=%b d=%h, want v=%b d=%h",
                   i, dv[3], dd[3], rq[i-2], (i == 4) ? prog[1] : prog[0]);
        end
      end
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL bubbles L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b1, 32'h10, 1'b1, 32'h10, 32'hDEADBEEF);
      else if (i == 1) step(1'b1, 32'h10, 1'b0, 32'h0, 32'h0);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (i < 2) begin
        n_cmp++;
        if (dv[1] !== 1'b1 || dd[1] !== ((i == 0) ? 32'h11111111 : 32'hDEADBEEF)) begin
          n_bad++;
          $display("FAIL same_edge%0d: got v=%b d=%h, want v=1 d=%h",
                   i, dv[1], dd[1], (i == 0) ? 32'h11111111 : 32'hDEADBEEF);
        end
      end
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL same_edge L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    // Everything in flight is gone
    for (int k = 0; k < HistN; k++) h_v[k] = 1'b0;
    for (int l = 1; l <= 3; l++) begin
      held[l] = 32'h0; ev[l] = 1'b0; ed[l] = 32'h0; ee[l] = 1'b0;
      n_cmp++;
      if (dv[l] !== 1'b0 || dd[l] !== 32'h0 || de[l] !== 1'b0) begin
        n_bad++;
        $display("FAIL async_reset L%0d: got v=%b d=%h e=%b, want v=0 d=00000000 e=0",
                 l, dv[l], dd[l], de[l]);
      end
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) step(1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (i < 4) begin
        n_cmp++;
        if (dv[2] !== 1'b0) begin
          n_bad++;
          $display("FAIL post_reset_quiet%0d: got v=%b, want v=0", i, dv[2]);
        end
      end
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL reset_inflight L%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int run;
    run = 0;
    for (int i = 0; i < 259; i++) begin
      if (i < 256) step(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      else step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      if (dv[3] === 1'b1) run++;
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL back_to_back L%0d i%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, i, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
    n_cmp++;
    if (run != 256) begin
      n_bad++;
      $display("FAIL back_to_back_count: got %0d valid responses, want 256", run);
    end
  endtask

  task automatic test_random();
    logic        req;
    logic        ld;
    logic [31:0] a;
    logic [31:0] la;
    int          r;
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7) a = {20'h0, 2'b00, 8'($urandom_range(0, 31)), 2'b00};
      else if (r == 7) a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'(Depth * 4) + {$urandom_range(0, 1023), 2'b00};
      else a = $urandom;
      ld = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 5) == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 31)), 2'b00};
      step(req, a, ld, la, $urandom);
      for (int l = 1; l <= 3; l++) begin
        n_cmp++;
        if (dv[l] !== ev[l] || dd[l] !== ed[l] || de[l] !== ee[l]) begin
          n_bad++;
          $display("FAIL random L%0d i%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                   l, i, dv[l], dd[l], de[l], ev[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    edge_n = 0;
    for (int k = 0; k < HistN; k++) begin
      h_v[k] = 1'b0; h_d[k] = 32'h0; h_e[k] = 1'b0;
    end
    for (int l = 1; l <= 3; l++) begin
      held[l] = 32'h0; ev[l] = 1'b0; ed[l] = 32'h0; ee[l] = 1'b0;
    end
    for (int k = 0; k < int'(Depth); k++) ref_mem[k] = 32'h0;
    reset_n   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = 32'h0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;

    test_reset();
    test_preload();
    test_program();
    test_errors();
    test_bubbles();
    test_same_edge();
    test_reset_inflight();
    test_back_to_back();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
